// File: rtl/game_state_sequencer_if.sv
// Control bundle between the frame/button logic and the game sequencer.
// master drives tick/flap and observes the renderer controls; slave is the sequencer.
interface game_state_sequencer_if;
    logic               frame_tick;
    logic               flap;
    logic [1:0]         screen;
    logic               bg_scroll;
    logic signed [31:0] bird_y;
    logic [31:0]        score;
    logic signed [31:0] pipe1_x;
    logic signed [31:0] pipe2_x;
    logic signed [31:0] pipe3_x;
    logic signed [31:0] pipe1_y;
    logic signed [31:0] pipe2_y;
    logic signed [31:0] pipe3_y;

    modport master (
        output frame_tick, flap,
        input  screen, bg_scroll, bird_y, score,
        input  pipe1_x, pipe2_x, pipe3_x, pipe1_y, pipe2_y, pipe3_y
    );

    modport slave (
        input  frame_tick, flap,
        output screen, bg_scroll, bird_y, score,
        output pipe1_x, pipe2_x, pipe3_x, pipe1_y, pipe2_y, pipe3_y
    );
endinterface

// File: rtl/game_state_sequencer.sv
// Per-frame game sequencer: TITLE/PLAY/GAME_OVER FSM, bird physics, pipe scroll, score, collision.
// Define PIPE_COLLISION_BYPASS_EN to drop pipe-overlap collision (ceiling/floor still end the game).
module game_state_sequencer #(
    parameter int              GRAVITY        = 1,
    parameter int              FLAP_VELOCITY  = -8,
    parameter int              MAX_FALL_SPEED = 10,
    parameter int              PIPE_SPEED     = 2,
    parameter int              PIPE_SPACING   = 240,
    parameter int              BIRD_START_Y   = 228,
    parameter int              PIPE_INIT_Y    = 140,
    parameter logic [15:0]     LFSR_SEED      = 16'hACE1,
    parameter int unsigned     HOLDOFF_FRAMES = 60
) (
    input  logic                 iClock,
    input  logic                 iReset,
    game_state_sequencer_if.slave bus
);

    localparam int ScreenW     = 640;
    localparam int ScreenH     = 480;
    localparam int BirdLeft    = 303;
    localparam int BirdRight   = 336;
    localparam int BirdH       = 24;
    localparam int PipeW       = 52;
    localparam int PipeGap     = 100;
    localparam int RespawnBase = 60;
    localparam int NumPipes    = 3;
    localparam int HoldW       = $clog2(HOLDOFF_FRAMES + 1);
    localparam logic [HoldW-1:0] HoldMax  = HoldW'(HOLDOFF_FRAMES);
    localparam logic [15:0]      LfsrMask = 16'hB400;

    typedef enum logic [1:0] {
        StTitle = 2'd0,
        StPlay  = 2'd1,
        StOver  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic               bg_q, bg_d;
    logic signed [31:0] bird_y_q, bird_y_d;
    logic signed [7:0]  vel_q, vel_d;
    logic [31:0]        score_q, score_d;
    logic signed [31:0] pipe_x_q [NumPipes];
    logic signed [31:0] pipe_x_d [NumPipes];
    logic signed [31:0] pipe_y_q [NumPipes];
    logic signed [31:0] pipe_y_d [NumPipes];
    logic               latch_q, latch_d;
    logic [HoldW-1:0]   hold_q, hold_d;
    logic [15:0]        lfsr_q, lfsr_d;

    logic               collision;
    logic               go_title;
    logic signed [31:0] vel_sum;
    logic signed [7:0]  vel_tick;
    logic signed [31:0] bird_y_tick;
    logic signed [31:0] pipe_x_tick [NumPipes];
    logic signed [31:0] pipe_y_tick [NumPipes];
    logic [1:0]         cross_cnt;
    logic [31:0]        score_sum;
    logic [31:0]        score_tick;

    // Collision from the registered outputs only.
    always_comb begin
        collision = 1'b0;
        if (bird_y_q < 0) collision = 1'b1;
        if (bird_y_q + BirdH > ScreenH) collision = 1'b1;
`ifndef PIPE_COLLISION_BYPASS_EN
        for (int i = 0; i < NumPipes; i++) begin
            if (pipe_x_q[i] <= BirdRight && pipe_x_q[i] + PipeW > BirdLeft) begin
                if (bird_y_q < pipe_y_q[i] || bird_y_q + BirdH > pipe_y_q[i] + PipeGap) begin
                    collision = 1'b1;
                end
            end
        end
`endif
    end

    // Candidate state after a PLAY frame tick.
    always_comb begin
        vel_sum = 32'(vel_q) + GRAVITY;
        if (latch_q || bus.flap) begin
            vel_tick = 8'(FLAP_VELOCITY);
        end else if (vel_sum > MAX_FALL_SPEED) begin
            vel_tick = 8'(MAX_FALL_SPEED);
        end else begin
            vel_tick = 8'(vel_sum);
        end
        bird_y_tick = bird_y_q + 32'(vel_tick);

        cross_cnt = 2'd0;
        for (int i = 0; i < NumPipes; i++) begin
            pipe_x_tick[i] = pipe_x_q[i] - PIPE_SPEED;
            pipe_y_tick[i] = pipe_y_q[i];
            if (pipe_x_q[i] + PipeW >= BirdLeft && pipe_x_tick[i] + PipeW < BirdLeft) begin
                cross_cnt = cross_cnt + 2'd1;
            end
            // Respawned pipes in the same tick all share this cycle's LFSR value.
            if (pipe_x_tick[i] < -PipeW) begin
                pipe_x_tick[i] = pipe_x_tick[i] + NumPipes * PIPE_SPACING;
                pipe_y_tick[i] = RespawnBase + 32'(lfsr_q[7:0]);
            end
        end
        score_sum  = score_q + 32'(cross_cnt);
        score_tick = (score_sum > 32'd999) ? 32'd999 : score_sum;
    end

    always_comb begin
        state_d  = state_q;
        bg_d     = bg_q;
        bird_y_d = bird_y_q;
        vel_d    = vel_q;
        score_d  = score_q;
        pipe_x_d = pipe_x_q;
        pipe_y_d = pipe_y_q;
        latch_d  = 1'b0;
        hold_d   = hold_q;
        lfsr_d   = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LfsrMask : 16'h0000);
        go_title = 1'b0;

        unique case (state_q)
            StTitle: begin
                if (bus.flap) begin
                    state_d = StPlay;
                    vel_d   = 8'(FLAP_VELOCITY);
                end
            end
            StPlay: begin
                latch_d = !bus.frame_tick && (latch_q || bus.flap);
                if (collision) begin
                    state_d = StOver;
                    bg_d    = 1'b0;
                end else if (bus.frame_tick) begin
                    vel_d    = vel_tick;
                    bird_y_d = bird_y_tick;
                    pipe_x_d = pipe_x_tick;
                    pipe_y_d = pipe_y_tick;
                    score_d  = score_tick;
                end
            end
            StOver: begin
                if (bus.flap && hold_q == HoldMax) begin
                    go_title = 1'b1;
                end else if (bus.frame_tick && hold_q != HoldMax) begin
                    hold_d = hold_q + HoldW'(1);
                end
            end
            default: go_title = 1'b1;
        endcase

        if (go_title) begin
            state_d  = StTitle;
            bg_d     = 1'b1;
            bird_y_d = BIRD_START_Y;
            vel_d    = '0;
            score_d  = '0;
            hold_d   = '0;
            latch_d  = 1'b0;
            for (int i = 0; i < NumPipes; i++) begin
                pipe_x_d[i] = ScreenW + i * PIPE_SPACING;
                pipe_y_d[i] = PIPE_INIT_Y;
            end
        end
    end

    always_ff @(posedge iClock) begin
        if (iReset) begin
            state_q  <= StTitle;
            bg_q     <= 1'b1;
            bird_y_q <= BIRD_START_Y;
            vel_q    <= '0;
            score_q  <= '0;
            latch_q  <= 1'b0;
            hold_q   <= '0;
            lfsr_q   <= LFSR_SEED;
            for (int i = 0; i < NumPipes; i++) begin
                pipe_x_q[i] <= ScreenW + i * PIPE_SPACING;
                pipe_y_q[i] <= PIPE_INIT_Y;
            end
        end else begin
            state_q  <= state_d;
            bg_q     <= bg_d;
            bird_y_q <= bird_y_d;
            vel_q    <= vel_d;
            score_q  <= score_d;
            latch_q  <= latch_d;
            hold_q   <= hold_d;
            lfsr_q   <= lfsr_d;
            pipe_x_q <= pipe_x_d;
            pipe_y_q <= pipe_y_d;
        end
    end

    assign bus.screen    = state_q;
    assign bus.bg_scroll = bg_q;
    assign bus.bird_y    = bird_y_q;
    assign bus.score     = score_q;
    assign bus.pipe1_x   = pipe_x_q[0];
    assign bus.pipe2_x   = pipe_x_q[1];
    assign bus.pipe3_x   = pipe_x_q[2];
    assign bus.pipe1_y   = pipe_y_q[0];
    assign bus.pipe2_y   = pipe_y_q[1];
    assign bus.pipe3_y   = pipe_y_q[2];

endmodule

// File: tb/tb_game_state_sequencer.sv
// Self-checking bench for game_state_sequencer: vector table, directed corner sequences,
// and randomized tick/flap/reset traffic against a behavioural game model.
module tb_game_state_sequencer;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    game_state_sequencer_if bus ();

    game_state_sequencer dut (
        .iClock (clk),
        .iReset (rst),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state: mode 0=title 1=play 2=game over.
    int          m_mode, m_bg, m_y, m_vel, m_score, m_latch, m_hold;
    int          m_px [3];
    int          m_py [3];
    logic [15:0] m_lfsr;

    function automatic void model_init();
        m_mode = 0; m_bg = 1; m_y = 228; m_vel = 0; m_score = 0; m_latch = 0; m_hold = 0;
        for (int i = 0; i < 3; i++) begin
            m_px[i] = 640 + i * 240;
            m_py[i] = 140;
        end
    endfunction

    function automatic bit model_collision();
        bit c;
        c = (m_y < 0) || (m_y + 24 > 480);
`ifndef PIPE_COLLISION_BYPASS_EN
        for (int i = 0; i < 3; i++)
            if (m_px[i] < 337 && m_px[i] + 52 > 303 && (m_y < m_py[i] || m_y + 24 > m_py[i] + 100))
                c = 1;
`endif
        return c;
    endfunction

    function automatic void model_step(bit r, bit t, bit f);
        logic [15:0] nl;
        bit          c;
        int          nv, cnt, nx;
        if (r) begin
            model_init();
            m_lfsr = 16'hACE1;
            return;
        end
        c  = model_collision();
        nl = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
        case (m_mode)
            0: if (f) begin m_mode = 1; m_vel = -8; end
            1: begin
                if (c) begin
                    m_mode = 2; m_bg = 0;
                end else if (t) begin
                    nv = (m_latch != 0 || f) ? -8 : ((m_vel + 1 > 10) ? 10 : m_vel + 1);
                    m_vel = nv;
                    m_y   = m_y + nv;
                    cnt   = 0;
                    for (int i = 0; i < 3; i++) begin
                        nx = m_px[i] - 2;
                        if (m_px[i] + 52 >= 303 && nx + 52 < 303) cnt++;
                        if (nx < -52) begin
                            nx      = nx + 720;
                            m_py[i] = 60 + int'(m_lfsr[7:0]);
                        end
                        m_px[i] = nx;
                    end
                    m_score = (m_score + cnt > 999) ? 999 : m_score + cnt;
                end
                m_latch = (!t && (m_latch != 0 || f)) ? 1 : 0;
            end
            default: begin
                m_latch = 0;
                if (f && m_hold == 60) model_init();
                else if (t && m_hold < 60) m_hold++;
            end
        endcase
        m_lfsr = nl;
    endfunction

    task automatic check(string name, longint act, longint exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model(string tag);
        check({tag, ".screen"}, bus.screen, m_mode);
        check({tag, ".bg_scroll"}, bus.bg_scroll, m_bg);
        check({tag, ".bird_y"}, bus.bird_y, m_y);
        check({tag, ".score"}, bus.score, m_score);
        check({tag, ".pipe1_x"}, bus.pipe1_x, m_px[0]);
        check({tag, ".pipe2_x"}, bus.pipe2_x, m_px[1]);
        check({tag, ".pipe3_x"}, bus.pipe3_x, m_px[2]);
        check({tag, ".pipe1_y"}, bus.pipe1_y, m_py[0]);
        check({tag, ".pipe2_y"}, bus.pipe2_y, m_py[1]);
        check({tag, ".pipe3_y"}, bus.pipe3_y, m_py[2]);
    endtask

    // One clock with the given inputs; outputs sampled 1ns after the edge.
    task automatic step(bit r, bit t, bit f);
        rst = r; bus.frame_tick = t; bus.flap = f;
        @(posedge clk);
        #1;
        model_step(r, t, f);
        rst = 1'b0; bus.frame_tick = 1'b0; bus.flap = 1'b0;
    endtask

    typedef struct {
        bit tick;
        bit flap;
        int screen;
        int bird_y;
        int pipe1_x;
        int score;
        int bg;
    } vec_t;

    vec_t tbl [10];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          prev_x, exp_y, pre_y;
        logic [15:0] pre_lfsr;
        bit          seen, done;

        for (int i = 0; i < 5; i++) tbl[i] = '{1, 0, 0, 228, 640, 0, 1};
        tbl[5] = '{0, 1, 1, 228, 640, 0, 1};
        tbl[6] = '{1, 0, 1, 221, 638, 0, 1};
        tbl[7] = '{1, 0, 1, 215, 636, 0, 1};
        tbl[8] = '{0, 0, 1, 215, 636, 0, 1};
        tbl[9] = '{1, 0, 1, 210, 634, 0, 1};

        rst = 1'b1; bus.frame_tick = 1'b0; bus.flap = 1'b0;
        step(1, 0, 0);
        step(1, 0, 0);
        check("reset.screen", bus.screen, 0);
        check("reset.bird_y", bus.bird_y, 228);
        check("reset.pipe1_x", bus.pipe1_x, 640);
        check("reset.pipe2_x", bus.pipe2_x, 880);
        check("reset.pipe3_x", bus.pipe3_x, 1120);
        check("reset.pipe1_y", bus.pipe1_y, 140);
        check("reset.score", bus.score, 0);
        check("reset.bg_scroll", bus.bg_scroll, 1);

        for (int i = 0; i < 10; i++) begin
            step(0, tbl[i].tick, tbl[i].flap);
            check($sformatf("vec%0d.screen", i), bus.screen, tbl[i].screen);
            check($sformatf("vec%0d.bird_y", i), bus.bird_y, tbl[i].bird_y);
            check($sformatf("vec%0d.pipe1_x", i), bus.pipe1_x, tbl[i].pipe1_x);
            check($sformatf("vec%0d.score", i), bus.score, tbl[i].score);
            check($sformatf("vec%0d.bg_scroll", i), bus.bg_scroll, tbl[i].bg);
            compare_model($sformatf("vec%0d", i));
        end

        // Steer the bird inside the initial gap until pipe1 scores and respawns.
        seen = 0;
        for (int n = 0; n < 500 && !seen; n++) begin
            prev_x   = m_px[0];
            pre_lfsr = m_lfsr;
            step(0, 1, m_y >= 190);
            compare_model("steer");
            if (prev_x == 253) check("score_at_x251", bus.score, 0);
            if (prev_x == 251) check("score_at_x249", bus.score, 1);
            if (prev_x - 2 < -52) begin
                seen  = 1;
                exp_y = 60 + int'(pre_lfsr[7:0]);
                check("respawn.pipe1_x", bus.pipe1_x, prev_x - 2 + 720);
                check("respawn.pipe1_y", bus.pipe1_y, exp_y);
                check("respawn.y_range", (bus.pipe1_y >= 60 && bus.pipe1_y <= 315), 1);
            end
        end
        check("respawn_seen", seen, 1);
        check("steer.still_play", bus.screen, 1);

        // Let it fall to a collision, ticking in the collision cycle.
        done = 0;
        for (int n = 0; n < 300 && !done; n++) begin
            if (model_collision()) begin
                pre_y = m_y;
                step(0, 1, 0);
                check("over.screen", bus.screen, 2);
                check("over.bg_scroll", bus.bg_scroll, 0);
                check("over.bird_y_frozen", bus.bird_y, pre_y);
                done = 1;
            end else begin
                step(0, 1, 0);
                compare_model("fall1");
            end
        end
        check("first_collision_seen", done, 1);

        // Holdoff: flaps at 30 and 59 ticks ignored, accepted at 60.
        for (int n = 0; n < 30; n++) begin step(0, 1, 0); compare_model("hold"); end
        step(0, 0, 1);
        check("holdoff30.screen", bus.screen, 2);
        for (int n = 0; n < 29; n++) begin step(0, 1, 0); compare_model("hold"); end
        step(0, 0, 1);
        check("holdoff59.screen", bus.screen, 2);
        step(0, 1, 0);
        step(0, 0, 1);
        check("holdoff60.screen", bus.screen, 0);
        check("holdoff60.score", bus.score, 0);
        check("holdoff60.bird_y", bus.bird_y, 228);
        check("holdoff60.pipe1_x", bus.pipe1_x, 640);
        check("holdoff60.bg_scroll", bus.bg_scroll, 1);
        compare_model("title2");

        // Free fall from the start position into the floor.
        step(0, 0, 1);
        check("replay.screen", bus.screen, 1);
        done = 0;
        for (int n = 0; n < 200 && !done; n++) begin
            if (model_collision()) begin
                check("floor_reached", (bus.bird_y + 24 > 480), 1);
                pre_y = m_y;
                step(0, 1, 0);
                check("floor.screen", bus.screen, 2);
                check("floor.bg_scroll", bus.bg_scroll, 0);
                check("floor.bird_y_frozen", bus.bird_y, pre_y);
                done = 1;
            end else begin
                step(0, 1, 0);
                compare_model("fall2");
            end
        end
        check("floor_collision_seen", done, 1);

        // Reset together with a flap while playing.
        step(1, 0, 0);
        step(0, 0, 1);
        for (int n = 0; n < 3; n++) step(0, 1, 0);
        check("pre_reset.screen", bus.screen, 1);
        step(1, 1, 1);
        check("rstflap.screen", bus.screen, 0);
        check("rstflap.bird_y", bus.bird_y, 228);
        check("rstflap.score", bus.score, 0);
        check("rstflap.pipe1_x", bus.pipe1_x, 640);
        check("rstflap.bg_scroll", bus.bg_scroll, 1);
        compare_model("rstflap");

        for (int n = 0; n < 5000; n++) begin
            step($urandom_range(0, 999) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 7) == 0);
            compare_model("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
